// File: rtl/com_bus_mem_responder_pkg.sv
// Shared constants and types for the snoop-bus memory responder.
package com_bus_mem_responder_pkg;

   localparam int NUM_REQ        = 8;
   localparam int ADDRESSSIZE    = 32;
   localparam int MEM_DEPTH_LOG2 = 10;
   localparam int MEM_LATENCY    = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RESPOND = 3'd3,
      ST_ABORT   = 3'd4
   } state_t;

   // Index reached by stepping 'offset' places past 'ptr' on a ring of n requesters.
   function automatic int rr_next(input int ptr, input int offset, input int n);
      return (ptr + offset) % n;
   endfunction

endpackage

// File: rtl/com_bus_rr_arbiter.sv
// Combinational round-robin picker: the first set request strictly after the
// pointer wins, so the last requester served has the lowest priority next time.
module com_bus_rr_arbiter #(
   parameter int N     = com_bus_mem_responder_pkg::NUM_REQ,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             upd_en,
   output logic [N-1:0]     gnt,
   output logic             gnt_vld,
   output logic [PTR_W-1:0] ptr_nxt
);
   import com_bus_mem_responder_pkg::*;

   logic [PTR_W-1:0] cand;
   logic [PTR_W-1:0] gnt_idx;

   // Search upward from ptr+1, wrapping, and keep only the first hit.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = PTR_W'(rr_next(int'(ptr), k, N));
         if (!gnt_vld && req[cand]) begin
            gnt_vld   = 1'b1;
            gnt_idx   = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

   assign ptr_nxt = (upd_en && gnt_vld) ? gnt_idx : ptr;

endmodule

// File: rtl/com_bus_mem_responder.sv
// Far end of the shared snoop bus: round-robin grant plus a fixed-latency
// word memory that answers the granted cache or yields to a snooping supplier.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no grant; arbitrate pending requests
// ST_CAPTURE | grant visible; latch address, direction and write data
// ST_WAIT    | latency down-counter running; watch for snoop supply
// ST_RESPOND | strobe (and read data) driven until the requester drops Req
// ST_ABORT   | another cache supplied the data; hold grant, drive nothing
module com_bus_mem_responder #(
   parameter int NUM_REQ        = com_bus_mem_responder_pkg::NUM_REQ,
   parameter int ADDRESSSIZE    = com_bus_mem_responder_pkg::ADDRESSSIZE,
   parameter int MEM_DEPTH_LOG2 = com_bus_mem_responder_pkg::MEM_DEPTH_LOG2,
   parameter int MEM_LATENCY    = com_bus_mem_responder_pkg::MEM_LATENCY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     Com_Bus_Req_proc,
   output logic [NUM_REQ-1:0]     Com_Bus_Gnt_proc,
   input  logic [ADDRESSSIZE-1:0] Address_Com,
   input  logic                   Mem_wr,
   inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
   inout  wire                    Data_in_Bus
);
   import com_bus_mem_responder_pkg::*;

   localparam int         PTR_W     = $clog2(NUM_REQ);
   localparam int         MEM_WORDS = 1 << MEM_DEPTH_LOG2;
   localparam logic [3:0] LAT_LOAD  = 4'(MEM_LATENCY - 1);

   state_t                    state_q, state_d;
   logic [NUM_REQ-1:0]        gnt_q, gnt_d, arb_gnt;
   logic                      arb_vld;
   logic [PTR_W-1:0]          rr_q, rr_nxt;
   logic [3:0]                cnt_q, cnt_d;
   logic [MEM_DEPTH_LOG2-1:0] idx_q;
   logic                      wr_q;
   logic [ADDRESSSIZE-1:0]    wdata_q, rdata_q;
   logic                      cap_en, mem_we, rd_en;
   logic                      req_held, snoop_seen;
   logic [ADDRESSSIZE-1:0]    mem [MEM_WORDS];
   logic                      unused_addr_hi;

   // Upper address bits alias onto the same words by design.
   assign unused_addr_hi = ^Address_Com[ADDRESSSIZE-1:MEM_DEPTH_LOG2];

   assign req_held   = |(Com_Bus_Req_proc & gnt_q);
   assign snoop_seen = (Data_in_Bus == 1'b1);

   com_bus_rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req     (Com_Bus_Req_proc),
      .ptr     (rr_q),
      .upd_en  (state_q == ST_IDLE),
      .gnt     (arb_gnt),
      .gnt_vld (arb_vld),
      .ptr_nxt (rr_nxt)
   );

   // State, grant, rr pointer and latency counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         rr_q    <= PTR_W'(NUM_REQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_nxt;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and control strobes; a dropped Req always wins over progress.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      cap_en  = 1'b0;
      mem_we  = 1'b0;
      rd_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               gnt_d   = arb_gnt;
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (!req_held) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cap_en  = 1'b1;
               cnt_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req_held) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else if (!wr_q && snoop_seen) begin
               state_d = ST_ABORT;
            end else if (cnt_q == 4'd0) begin
               mem_we  = wr_q;
               rd_en   = !wr_q;
               state_d = ST_RESPOND;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESPOND, ST_ABORT: begin
            if (!req_held) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Transaction capture: word index, direction, and write data while granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else if (cap_en) begin
         idx_q <= Address_Com[MEM_DEPTH_LOG2-1:0];
         wr_q  <= Mem_wr;
         if (Mem_wr) begin
            wdata_q <= Data_Bus_Com;
         end
      end
   end

   // Memory array: contents survive reset; read data is registered on entry to RESPOND.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
      if (rd_en) begin
         rdata_q <= mem[idx_q];
      end
   end

   assign Com_Bus_Gnt_proc = gnt_q;
   assign Data_in_Bus      = (state_q == ST_RESPOND) ? 1'b1 : 1'bz;
   assign Data_Bus_Com     = (state_q == ST_RESPOND && !wr_q) ? rdata_q
                                                              : {ADDRESSSIZE{1'bz}};

endmodule

// File: tb/tb_com_bus_mem_responder.sv
// Scoreboard bench for the snoop-bus memory responder.
module tb_com_bus_mem_responder;

   localparam int NR  = 8;
   localparam int AW  = 32;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [NR-1:0] gnt;
   logic [AW-1:0] addr;
   logic          mem_wr;
   logic [AW-1:0] tb_data;
   logic          tb_data_en;
   logic          tb_strb_en;
   wire  [AW-1:0] data_bus;
   wire           data_strb;

   assign data_bus  = tb_data_en ? tb_data : {AW{1'bz}};
   assign data_strb = tb_strb_en ? 1'b1 : 1'bz;

   int            n_chk = 0;
   int            n_err = 0;
   logic [AW-1:0] exp_q [$];
   logic [AW-1:0] mem_model [logic [9:0]];

   always #5 clk = ~clk;

   com_bus_mem_responder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Com_Bus_Req_proc (req),
      .Com_Bus_Gnt_proc (gnt),
      .Address_Com      (addr),
      .Mem_wr           (mem_wr),
      .Data_Bus_Com     (data_bus),
      .Data_in_Bus      (data_strb)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bus_free();
      return ($isunknown(data_bus) || data_bus == '0) ? 32'd1 : 32'd0;
   endfunction

   function automatic logic [31:0] strb_high();
      return (data_strb === 1'b1) ? 32'd1 : 32'd0;
   endfunction

   task automatic wait_gnt(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (gnt != '0) got = 1'b1;
      end
   endtask

   // Full transaction for requester idx, whose Req the caller has already raised.
   task automatic serve(input int idx, input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input bit rst_mid);
      bit            got;
      int            lat;
      logic [31:0]   exp_gnt;
      logic [31:0]   exp_rd;
      exp_gnt = 32'd1 << idx;
      wait_gnt(got);
      check_eq("gnt", 32'(gnt), exp_gnt);
      if (!got) begin
         req[idx] = 1'b0;
         return;
      end
      addr   = a;
      mem_wr = wr;
      if (wr) begin
         tb_data    = wd;
         tb_data_en = 1'b1;
         mem_model[a[9:0]] = wd;
      end else begin
         exp_q.push_back(mem_model[a[9:0]]);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) tb_data_en = 1'b0;
      end while (data_strb !== 1'b1 && lat < 20);
      check_eq("latency", 32'(lat), 32'(LAT + 1));
      check_eq("gnt_hold", 32'(gnt), exp_gnt);
      if (!wr) begin
         exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         check_eq("rdata", data_bus, exp_rd);
      end else begin
         check_eq("wr_bus_free", bus_free(), 32'd1);
      end
      @(negedge clk);
      check_eq("strb_hold", strb_high(), 32'd1);
      if (rst_mid) begin
         #2 rst_n = 1'b0;
         #1;
         check_eq("rst_gnt", 32'(gnt), 32'd0);
         check_eq("rst_strb", strb_high(), 32'd0);
         check_eq("rst_bus", bus_free(), 32'd1);
         @(negedge clk);
         req[idx] = 1'b0;
         mem_wr   = 1'b0;
         rst_n    = 1'b1;
      end else begin
         req[idx] = 1'b0;
         mem_wr   = 1'b0;
         @(negedge clk);
         check_eq("drop_gnt", 32'(gnt), 32'd0);
         check_eq("drop_strb", strb_high(), 32'd0);
         check_eq("drop_bus", bus_free(), 32'd1);
      end
   endtask

   initial begin
      bit got;
      bit quiet;
      req        = '0;
      addr       = '0;
      mem_wr     = 1'b0;
      tb_data    = '0;
      tb_data_en = 1'b0;
      tb_strb_en = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_gnt", 32'(gnt), 32'd0);
      check_eq("reset_strb", strb_high(), 32'd0);
      check_eq("reset_bus", bus_free(), 32'd1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_gnt", 32'(gnt), 32'd0);

      // Known contents for later reads.
      req[4] = 1'b1; serve(4, 32'h10, 1'b1, 32'h10, 1'b0);
      req[6] = 1'b1; serve(6, 32'h30, 1'b1, 32'h30, 1'b0);

      // Single read, write then read, aliased read.
      req[2] = 1'b1; serve(2, 32'h10,  1'b0, '0, 1'b0);
      req[0] = 1'b1; serve(0, 32'h20,  1'b1, 32'hDEAD_BEEF, 1'b0);
      req[5] = 1'b1; serve(5, 32'h20,  1'b0, '0, 1'b0);
      req[7] = 1'b1; serve(7, 32'h420, 1'b0, '0, 1'b0);

      // Snoop supply from another cache during WAIT.
      req[3] = 1'b1;
      wait_gnt(got);
      check_eq("snoop_gnt", 32'(gnt), 32'h08);
      addr   = 32'h10;
      mem_wr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tb_strb_en = 1'b1;
      @(negedge clk);
      tb_strb_en = 1'b0;
      #1;
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (bus_free() != 32'd1 || data_strb === 1'b1) quiet = 1'b0;
         @(negedge clk);
      end
      check_eq("snoop_quiet", 32'(quiet), 32'd1);
      check_eq("snoop_gnt_hold", 32'(gnt), 32'h08);
      req[3] = 1'b0;
      @(negedge clk);
      check_eq("snoop_drop_gnt", 32'(gnt), 32'd0);

      // Cancelled write: Req drops in WAIT before the counter expires.
      req[1] = 1'b1;
      wait_gnt(got);
      check_eq("cancel_gnt", 32'(gnt), 32'h02);
      addr       = 32'h30;
      mem_wr     = 1'b1;
      tb_data    = 32'hBAD0_BAD0;
      tb_data_en = 1'b1;
      @(negedge clk);
      tb_data_en = 1'b0;
      @(negedge clk);
      req[1] = 1'b0;
      mem_wr = 1'b0;
      @(negedge clk);
      check_eq("cancel_gnt_clr", 32'(gnt), 32'd0);
      req[6] = 1'b1; serve(6, 32'h30, 1'b0, '0, 1'b0);

      // Reset in RESPOND, then a fresh request; memory survives reset.
      req[2] = 1'b1; serve(2, 32'h10, 1'b0, '0, 1'b1);
      @(negedge clk);
      req[0] = 1'b1; serve(0, 32'h20, 1'b0, '0, 1'b0);

      // Round robin from a freshly reset pointer with every cache requesting.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req = '1;
      for (int k = 0; k < 9; k++) begin
         serve(k % NR, (k % 2 == 1) ? 32'h10 : 32'h20, 1'b0, '0, 1'b0);
         if (k == 0) req[0] = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
